// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and default bit timing.
`timescale 1ns/1ps
package uart_pkg;

    // Default clock cycles per serial bit, also used by the receiver side.
    localparam int CLKS_PER_BIT_DEFAULT = 16;

    // Transmitter state encoding (3 bits).
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } uart_state_t;

    // Width of an index that counts 0..w-1, never narrower than one bit.
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud-rate divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
`timescale 1ns/1ps
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_reg;

    // Free-running bit-period counter, held at zero while cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear || (count_reg == LAST)) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign bit_end = !clear && (count_reg == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter that pops words from an upstream FIFO and sends 8N1-style frames.
`timescale 1ns/1ps
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int WIDTH        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_get,
    output logic             tx,
    output logic             busy
);

    localparam int IW = idx_width(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    uart_state_t      state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [WIDTH-1:0] shift_down;
    logic [IW-1:0]    idx_reg, idx_next;
    logic             tx_reg, tx_next;
    logic             busy_reg, busy_next;
    logic             baud_clear;
    logic             bit_end;

    // The bit timer only runs once the start bit is on the line.
    assign baud_clear = (state_reg == ST_IDLE) || (state_reg == ST_WAIT);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .clear  (baud_clear),
        .bit_end(bit_end)
    );

    // Pop only from a settled IDLE state; gated by reset so nothing is lost while held.
    assign fifo_get = (state_reg == ST_IDLE) && !fifo_empty && !reset;

    assign shift_down = shift_reg >> 1;

    // State register plus the shift, index and line registers it controls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            shift_reg <= '0;
            idx_reg   <= '0;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            idx_reg   <= idx_next;
            tx_reg    <= tx_next;
            busy_reg  <= busy_next;
        end
    end

    // Next-state and datapath decisions; everything holds unless a transition fires.
    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        idx_next   = idx_reg;
        tx_next    = tx_reg;
        busy_next  = busy_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_next = ST_WAIT;
                    busy_next  = 1'b1;
                end
            end
            ST_WAIT: begin
                // FIFO output is valid one cycle after the pop.
                shift_next = fifo_data;
                tx_next    = 1'b0;
                state_next = ST_START;
            end
            ST_START: begin
                if (bit_end) begin
                    tx_next    = shift_reg[0];
                    idx_next   = '0;
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (idx_reg == LAST_IDX) begin
                        tx_next    = 1'b1;
                        state_next = ST_STOP;
                    end else begin
                        shift_next = shift_down;
                        tx_next    = shift_down[0];
                        idx_next   = idx_reg + IW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_next = ST_IDLE;
                    busy_next  = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign tx   = tx_reg;
    assign busy = busy_reg;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Testbench for uart_tx_drain: FIFO model with registered output, frame reference model.
`timescale 1ns/1ps
module tb_uart_tx_drain;

    localparam int CPB   = 4;
    localparam int W     = 8;
    localparam int FRAME = (W + 2) * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_get;
    logic       tx;
    logic       busy;

    // FIFO model storage
    logic [7:0] mem [0:15];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       empty_force_low = 1'b0;
    int         pop_count = 0;
    int         bad_get = 0;
    int         cyc = 0;

    int checks = 0;
    int errors = 0;
    int exp_pops = 0;

    assign fifo_empty = empty_force_low ? 1'b0 : (wr_ptr == rd_ptr);

    uart_tx_drain #(
        .CLKS_PER_BIT(CPB),
        .WIDTH       (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_get  (fifo_get),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // FIFO pop with registered data_out; counts every pop strobe seen
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_get) begin
            pop_count <= pop_count + 1;
            if (wr_ptr != rd_ptr) begin
                fifo_data <= mem[rd_ptr % 16];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    // Watch for pops requested against an empty FIFO
    always @(negedge clk) begin
        if (fifo_get && fifo_empty) bad_get <= bad_get + 1;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr % 16] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    // Expected line level at cycle i of a frame: start, LSB-first data, stop.
    function automatic logic ref_level(input logic [7:0] d, input int i);
        int b;
        b = i / CPB;
        if (b == 0) return 1'b0;
        if (b <= W) return d[b-1];
        return 1'b1;
    endfunction

    task automatic wait_get();
        bit ok;
        ok = 0;
        #1;
        if (fifo_get) ok = 1;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            if (fifo_get) ok = 1;
        end
        chk("get_seen", 32'(ok), 32'd1);
        if (ok) exp_pops++;
        $display("pop observed at cycle %0d", cyc);
    endtask

    // Called in the cycle where fifo_get is high; follows the whole frame.
    task automatic do_frame(input logic [7:0] d, input bit more, input int glitch_at);
        logic [7:0] dec;
        int b;
        dec = 8'h00;
        @(negedge clk);
        chk("wait_tx", 32'(tx), 32'd1);
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_get", 32'(fifo_get), 32'd0);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            chk("tx_level", 32'(tx), 32'(ref_level(d, i)));
            chk("busy_frame", 32'(busy), 32'd1);
            chk("get_in_frame", 32'(fifo_get), 32'd0);
            b = i / CPB;
            if ((i % CPB) == CPB / 2 && b >= 1 && b <= W) dec[b-1] = tx;
            empty_force_low = (i == glitch_at);
        end
        empty_force_low = 1'b0;
        chk("decode", 32'(dec), 32'(d));
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_tx", 32'(tx), 32'd1);
        chk("next_get", 32'(fifo_get), 32'(more));
        $display("frame data=%02h decoded=%02h more=%0d", d, dec, more);
    endtask

    initial begin
        logic [7:0] words [0:7];
        int c1;
        int c2;

        // 1: reset with FIFO empty, hold 20 cycles; a word arrives late in reset
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("rst_tx", 32'(tx), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_get", 32'(fifo_get), 32'd0);
            if (i == 17) push(8'hA5);
        end
        $display("reset hold done, pops=%0d", pop_count);
        chk("rst_no_pop", 32'(pop_count), 32'd0);
        reset = 1'b0;

        // 2: single word 0xA5
        wait_get();
        do_frame(8'hA5, 1'b0, -1);
        chk("pops_a5", 32'(pop_count), 32'(exp_pops));

        // 3: back-to-back 0x00, 0xFF
        push(8'h00);
        push(8'hFF);
        wait_get();
        c1 = cyc;
        do_frame(8'h00, 1'b1, -1);
        c2 = cyc;
        chk("frame_period", 32'(c2 - c1), 32'(FRAME + 2));
        wait_get();
        do_frame(8'hFF, 1'b0, -1);
        chk("pops_b2b", 32'(pop_count), 32'(exp_pops));

        // 4: eight queued words, mixing in a few random ones
        for (int k = 0; k < 8; k++) begin
            words[k] = (k < 4) ? 8'(k + 1) : 8'($urandom_range(0, 255));
            push(words[k]);
        end
        for (int k = 0; k < 8; k++) begin
            wait_get();
            do_frame(words[k], (k < 7), -1);
        end
        chk("pops_burst", 32'(pop_count), 32'(exp_pops));
        chk("fifo_drained", 32'(fifo_empty), 32'd1);
        chk("burst_busy", 32'(busy), 32'd0);

        // 5: asynchronous reset during data bit 3 of 0x3C
        push(8'h3C);
        wait_get();
        @(negedge clk);
        for (int i = 0; i <= 4 * CPB + 1; i++) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_tx", 32'(tx), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_get", 32'(fifo_get), 32'd0);
        $display("async reset applied at cycle %0d", cyc);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("post_rst_get", 32'(fifo_get), 32'd0);
            chk("post_rst_tx", 32'(tx), 32'd1);
        end
        chk("pops_arst", 32'(pop_count), 32'(exp_pops));

        // 6: one-cycle non-empty glitch during STOP, then a real word
        push(8'h5A);
        wait_get();
        do_frame(8'h5A, 1'b0, FRAME - 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("glitch_get", 32'(fifo_get), 32'd0);
        end
        chk("pops_glitch", 32'(pop_count), 32'(exp_pops));
        push(8'($urandom_range(0, 255)));
        wait_get();
        do_frame(mem[(wr_ptr - 1) % 16], 1'b0, -1);
        chk("pops_final", 32'(pop_count), 32'(exp_pops));
        chk("bad_get", 32'(bad_get), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
